// File: rtl/knight_cmd_exec.sv
// Knight command responder: decodes UART commands and runs calibration or a move.
// A move aligns the heading, ramps forward speed up, counts line crossings, then ramps down.
module knight_cmd_exec #(
    parameter logic [9:0]  FRWRD_INC = 10'h018,
    parameter logic [9:0]  MAX_FRWRD = 10'h2A0,
    parameter logic [11:0] HDNG_TOL  = 12'h02C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    input  logic        cal_done,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic        strt_cal,
    output logic        moving,
    output logic [11:0] dsrd_hdng,
    output logic [9:0]  frwrd,
    output logic        fanfare,
    output logic        send_resp
);

    localparam logic [9:0] FRWRD_DEC = FRWRD_INC << 1;

    typedef enum logic [2:0] {IDLE, CAL, HDNG, RAMPUP, RAMPDN} state_t;

    state_t      state, nxt_state;
    logic [3:0]  squares, nxt_squares;
    logic        fan_en, nxt_fan_en;
    logic [4:0]  sq_cnt, nxt_sq_cnt;
    logic        cntr_ff;
    logic        cntr_rise;
    logic [9:0]  nxt_frwrd;
    logic [11:0] nxt_dsrd;
    logic        nxt_moving, nxt_clr, nxt_strt, nxt_resp, nxt_fan;

    function automatic logic [9:0] sat_inc(input logic [9:0] f);
        logic [10:0] sum;
        sum = {1'b0, f} + {1'b0, FRWRD_INC};
        return (sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : sum[9:0];
    endfunction

    // 0x800 has no positive twin in 12 bits, so it is rejected outright.
    function automatic logic in_tol(input logic [11:0] want, input logic [11:0] cur);
        logic [11:0]        diff;
        logic signed [11:0] err;
        logic [11:0]        mag;
        diff = want - cur;
        err  = signed'(diff);
        mag  = err[11] ? unsigned'(-err) : diff;
        return (diff != 12'h800) && (mag < HDNG_TOL);
    endfunction

    assign cntr_rise = cntrIR & ~cntr_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state   = state;
        nxt_squares = squares;
        nxt_fan_en  = fan_en;
        nxt_sq_cnt  = sq_cnt;
        nxt_frwrd   = frwrd;
        nxt_dsrd    = dsrd_hdng;
        nxt_moving  = moving;
        nxt_clr     = 1'b0;
        nxt_strt    = 1'b0;
        nxt_resp    = 1'b0;
        nxt_fan     = 1'b0;

        if ((state == RAMPUP || state == RAMPDN) && cntr_rise)
            nxt_sq_cnt = sq_cnt + 5'd1;

        case (state)
            IDLE: begin
                // cmd_rdy drops one clock after clr_cmd_rdy; skip that clock to avoid a double accept.
                if (cmd_rdy && !clr_cmd_rdy) begin
                    nxt_clr = 1'b1;
                    if (cmd[15:12] == 4'b0000) begin
                        nxt_strt  = 1'b1;
                        nxt_state = CAL;
                    end else if (cmd[15:13] == 3'b001) begin
                        nxt_state   = HDNG;
                        nxt_moving  = 1'b1;
                        nxt_frwrd   = 10'h000;
                        nxt_sq_cnt  = 5'd0;
                        nxt_squares = cmd[3:0];
                        nxt_fan_en  = cmd[12];
                        nxt_dsrd    = (cmd[11:4] != 8'h00) ? {cmd[11:4], 4'hF} : 12'h000;
                    end
                end
            end
            CAL: begin
                if (cal_done) begin
                    nxt_resp  = 1'b1;
                    nxt_state = IDLE;
                end
            end
            HDNG: begin
                if (heading_rdy && in_tol(dsrd_hdng, heading)) begin
                    if (squares == 4'd0) begin
                        nxt_resp   = 1'b1;
                        nxt_fan    = fan_en;
                        nxt_moving = 1'b0;
                        nxt_state  = IDLE;
                    end else begin
                        nxt_state = RAMPUP;
                    end
                end
            end
            RAMPUP: begin
                if (heading_rdy)
                    nxt_frwrd = sat_inc(frwrd);
                if (sq_cnt == {squares, 1'b0})
                    nxt_state = RAMPDN;
            end
            RAMPDN: begin
                if (heading_rdy) begin
                    if (frwrd <= FRWRD_DEC) begin
                        nxt_frwrd  = 10'h000;
                        nxt_moving = 1'b0;
                        nxt_resp   = 1'b1;
                        nxt_fan    = fan_en;
                        nxt_state  = IDLE;
                    end else begin
                        nxt_frwrd = frwrd - FRWRD_DEC;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squares     <= 4'd0;
            fan_en      <= 1'b0;
            sq_cnt      <= 5'd0;
            cntr_ff     <= 1'b0;
            frwrd       <= 10'h000;
            dsrd_hdng   <= 12'h000;
            moving      <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            strt_cal    <= 1'b0;
            send_resp   <= 1'b0;
            fanfare     <= 1'b0;
        end else begin
            squares     <= nxt_squares;
            fan_en      <= nxt_fan_en;
            sq_cnt      <= nxt_sq_cnt;
            cntr_ff     <= cntrIR;
            frwrd       <= nxt_frwrd;
            dsrd_hdng   <= nxt_dsrd;
            moving      <= nxt_moving;
            clr_cmd_rdy <= nxt_clr;
            strt_cal    <= nxt_strt;
            send_resp   <= nxt_resp;
            fanfare     <= nxt_fan;
        end
    end

endmodule

// File: tb/tb_knight_cmd_exec.sv
// Randomized bench for knight_cmd_exec against a transaction-level model of moves,
// calibration and illegal commands.
module tb_knight_cmd_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        cmd_rdy = 1'b0;
    logic        cal_done = 1'b0;
    logic [11:0] heading = 12'h000;
    logic        heading_rdy = 1'b0;
    logic        cntrIR = 1'b0;
    logic        clr_cmd_rdy, strt_cal, moving, fanfare, send_resp;
    logic [11:0] dsrd_hdng;
    logic [9:0]  frwrd;

    int n_pass = 0;
    int n_chk  = 0;
    int n_resp = 0, n_fan = 0, n_clr = 0, n_strt = 0;
    logic [11:0] hq[$];

    knight_cmd_exec dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .cal_done(cal_done), .heading(heading), .heading_rdy(heading_rdy), .cntrIR(cntrIR),
        .strt_cal(strt_cal), .moving(moving), .dsrd_hdng(dsrd_hdng), .frwrd(frwrd),
        .fanfare(fanfare), .send_resp(send_resp)
    );

    always #5 clk = ~clk;

    // High-level counts: each one-clock pulse adds exactly one.
    always @(negedge clk) begin
        if (send_resp)   n_resp++;
        if (fanfare)     n_fan++;
        if (clr_cmd_rdy) n_clr++;
        if (strt_cal)    n_strt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hr_pulse();
        heading_rdy = 1'b1;
        cyc(1);
        heading_rdy = 1'b0;
    endtask

    function automatic bit tol_ok(input logic [11:0] w, input logic [11:0] c);
        int e;
        e = (int'(w) - int'(c) + 4096) % 4096;
        if (e >= 2048) e -= 4096;
        return (e > -44) && (e < 44);
    endfunction

    function automatic int up(input int f);
        return (f + 24 > 672) ? 672 : f + 24;
    endfunction

    task automatic send_cmd(input logic [15:0] c);
        cmd = c;
        cmd_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (clr_cmd_rdy) break;
        end
        chk("clr_seen", clr_cmd_rdy, 1);
        cmd_rdy = 1'b0;
    endtask

    task automatic do_cal(input int lat);
        int r0, s0;
        r0 = n_resp; s0 = n_strt;
        send_cmd({4'b0000, 12'($urandom)});
        chk("strt_cal", strt_cal, 1);
        cyc(lat);
        chk("cal_wait", n_resp - r0, 0);
        cal_done = 1'b1;
        cyc(1);
        cal_done = 1'b0;
        chk("cal_resp", send_resp, 1);
        cyc(2);
        chk("cal_resp_cnt", n_resp - r0, 1);
        chk("cal_strt_cnt", n_strt - s0, 1);
    endtask

    task automatic do_illegal(input logic [3:0] op);
        int r0, c0, s0;
        r0 = n_resp; c0 = n_clr; s0 = n_strt;
        send_cmd({op, 12'($urandom)});
        cal_done = 1'b1;
        cyc(1);
        cal_done = 1'b0;
        cyc(3);
        chk("ill_resp", n_resp - r0, 0);
        chk("ill_strt", n_strt - s0, 0);
        chk("ill_clr", n_clr - c0, 1);
        chk("ill_mov", moving, 0);
    endtask

    // mode 0: plain, 1: second command pending while busy, 2: reset during ramp-up
    task automatic do_move(input logic fan, input logic [7:0] hd8, input logic [3:0] sq, input int mode);
        int r0, f0, c0, s0, f, n_up;
        logic [11:0] want;
        bit ok, done, sync;
        r0 = n_resp; f0 = n_fan; c0 = n_clr; s0 = n_strt;
        want = (hd8 != 8'h00) ? {hd8, 4'hF} : 12'h000;
        send_cmd({3'b001, fan, hd8, sq});
        chk("dsrd", dsrd_hdng, want);
        chk("mov_on", moving, 1);
        chk("frwrd_hdng", frwrd, 0);

        for (int a = 0; a < 6; a++) begin
            if (hq.size() > 0)             heading = hq.pop_front();
            else if (a >= 3)               heading = want + 12'($urandom_range(0, 86)) - 12'd43;
            else if ($urandom_range(0, 1)) heading = 12'($urandom);
            else                           heading = want + 12'($urandom_range(0, 120)) - 12'd60;
            ok = tol_ok(want, heading);
            hr_pulse();
            if (ok) break;
            chk("hdng_hold_f", frwrd, 0);
            chk("hdng_hold_r", n_resp - r0, 0);
        end

        if (sq == 4'd0) begin
            chk("zero_resp", send_resp, 1);
            chk("zero_fan", fanfare, fan);
            chk("zero_frwrd", frwrd, 0);
            chk("zero_mov", moving, 0);
            cyc(2);
            chk("zero_resp_cnt", n_resp - r0, 1);
            chk("zero_fan_cnt", n_fan - f0, fan);
            return;
        end

        f = 0;
        n_up = $urandom_range(1, 32);
        for (int k = 0; k < n_up; k++) begin
            hr_pulse();
            f = up(f);
            chk("rampup", frwrd, f);
        end

        if (mode != 0) begin
            cmd = 16'h5000;
            cmd_rdy = 1'b1;
            cyc(2);
            chk("busy_clr_held", n_clr - c0, 1);
        end
        if (mode == 2) begin
            rst_n = 1'b0;
            #2;
            chk("rst_frwrd", frwrd, 0);
            chk("rst_mov", moving, 0);
            chk("rst_dsrd", dsrd_hdng, 0);
            cyc(2);
            rst_n = 1'b1;
            cyc(1);
            chk("rst_reconsume", clr_cmd_rdy, 1);
            cmd_rdy = 1'b0;
            cyc(2);
            chk("rst_no_resp", n_resp - r0, 0);
            return;
        end

        sync = (mode == 0) && ($urandom_range(0, 2) == 0);
        for (int i = 0; i < 2 * sq; i++) begin
            cntrIR = 1'b1;
            if (i == 2 * sq - 1 && sync) begin
                cyc(1);
                heading_rdy = 1'b1;
                cyc(1);
                heading_rdy = 1'b0;
                f = up(f);
                chk("sync_up", frwrd, f);
            end else begin
                cyc($urandom_range(1, 3));
            end
            cntrIR = 1'b0;
            cyc($urandom_range(1, 3));
            if (i == sq - 1) begin
                hr_pulse();
                f = up(f);
                chk("mid_up", frwrd, f);
            end
        end
        cyc(2);
        chk("up_no_resp", n_resp - r0, 0);
        if ($urandom_range(0, 1)) begin
            cntrIR = 1'b1;
            cyc(2);
            cntrIR = 1'b0;
            cyc(1);
        end

        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            hr_pulse();
            if (f <= 48) begin
                f = 0;
                done = 1'b1;
            end else begin
                f -= 48;
            end
            chk("rampdn", frwrd, f);
        end
        chk("dn_resp", send_resp, 1);
        chk("dn_fan", fanfare, fan);
        chk("dn_mov", moving, 0);
        if (mode == 1) begin
            cyc(1);
            chk("busy_clr", clr_cmd_rdy, 1);
            cmd_rdy = 1'b0;
        end
        cyc(2);
        chk("resp_cnt", n_resp - r0, 1);
        chk("fan_cnt", n_fan - f0, fan);
        chk("strt_cnt", n_strt - s0, 0);
        chk("clr_cnt", n_clr - c0, (mode == 1) ? 2 : 1);
    endtask

    initial begin
        cyc(3);
        chk("rst_frwrd0", frwrd, 0);
        chk("rst_mov0", moving, 0);
        chk("rst_dsrd0", dsrd_hdng, 0);
        chk("rst_pulses0", {send_resp, fanfare, clr_cmd_rdy, strt_cal}, 0);
        rst_n = 1'b1;
        cyc(2);

        do_cal(50);
        do_illegal(4'h5);
        do_move(1'b0, 8'h00, 4'd1, 0);
        hq.push_back(12'h800);
        hq.push_back(12'hFF0);
        do_move(1'b0, 8'h00, 4'd2, 0);
        hq.push_back(12'h000);
        hq.push_back(12'hBF0);
        do_move(1'b1, 8'hBF, 4'd2, 0);
        hq.push_back(12'h7FF);
        do_move(1'b0, 8'h70, 4'd0, 0);
        do_move(1'b1, 8'h3F, 4'd1, 1);
        do_move(1'b0, 8'h7F, 4'd3, 2);
        do_move(1'b1, 8'h00, 4'd0, 0);

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 5))
                0:       do_cal($urandom_range(1, 20));
                1:       do_illegal(($urandom_range(0, 1) != 0) ? 4'h1 : 4'($urandom_range(4, 15)));
                default: do_move(1'($urandom), 8'($urandom), 4'($urandom_range(0, 6)), 0);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
